// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and a small FWFT receive FIFO.
// Sticky frame/overrun flags are cleared by err_clr; a new error wins.
module uart_rx_fifo #(
  parameter int OVS_DIV    = 651,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] rx_count,
  output logic             frame_err,
  output logic             overrun
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] TICK_MAX = 16'(OVS_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic             r_sync1;
  logic             r_rxd_s;
  logic [15:0]      r_tick_cnt;
  logic             w_tick;

  state_t           r_state;
  state_t           w_state;
  logic [3:0]       r_sample_cnt;
  logic [3:0]       w_sample_cnt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift;
  logic             w_stop_smp;
  logic             w_push_req;
  logic             w_frame_bad;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_ovr;

  assign w_tick = (r_tick_cnt == TICK_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_tick_cnt <= '0;
    end else begin
      r_sync1    <= rxd;
      r_rxd_s    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sample_cnt <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
    end else begin
      r_state      <= w_state;
      r_sample_cnt <= w_sample_cnt;
      r_bit_idx    <= w_bit_idx;
      r_shift      <= w_shift;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_sample_cnt = r_sample_cnt;
    w_bit_idx    = r_bit_idx;
    w_shift      = r_shift;
    w_stop_smp   = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_rxd_s) begin
            w_state      = S_START;
            w_sample_cnt = '0;
          end
        end
        S_START: begin
          if (r_sample_cnt == 4'd7) begin
            w_sample_cnt = '0;
            w_bit_idx    = '0;
            w_state      = r_rxd_s ? S_IDLE : S_DATA;
          end else begin
            w_sample_cnt = r_sample_cnt + 4'd1;
          end
        end
        S_DATA: begin
          if (r_sample_cnt == 4'd15) begin
            w_sample_cnt = '0;
            w_shift      = {r_rxd_s, r_shift[7:1]};
            w_bit_idx    = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) w_state = S_STOP;
          end else begin
            w_sample_cnt = r_sample_cnt + 4'd1;
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is seen
          if (r_sample_cnt == 4'd15) begin
            w_sample_cnt = '0;
            w_state      = S_IDLE;
            w_stop_smp   = 1'b1;
          end else begin
            w_sample_cnt = r_sample_cnt + 4'd1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign w_push_req  = w_stop_smp & r_rxd_s;
  assign w_frame_bad = w_stop_smp & ~r_rxd_s;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = rd_en & ~w_empty;
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_ovr   = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_frame_bad)  r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
      if (w_ovr)        r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

  assign rx_valid  = ~w_empty;
  assign rx_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign rx_count  = r_count;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receive front end for the UART path: samples the asynchronous `rxd` pin and deframes 8N1 characters. Buffers received bytes in a small FIFO read by the Peripheral block's UART data register. Sits between the board `rxd` pin and the Peripheral bus logic, in the same clock domain as the Peripheral's UART logic.

Parameters:
OVS_DIV, 651, clk cycles per oversample tick; 16 ticks per bit (651 = 100 MHz / (9600*16)); legal range 2..65535
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16
CNT_W, 3, width of rx_count; must equal log2(FIFO_DEPTH)+1

Ports:
clk  input  1  block clock, rising edge
reset  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk edge)
rxd  input  1  asynchronous serial line, idle high
rd_en  input  1  pop request for the FIFO head; honoured only when rx_valid=1
err_clr  input  1  one-cycle pulse that clears frame_err and overrun
rx_data  output  8  FIFO head byte, first-word-fall-through; 8'h00 when FIFO is empty
rx_valid  output  1  FIFO non-empty
rx_count  output  CNT_W  number of stored bytes, 0..FIFO_DEPTH
frame_err  output  1  sticky: a stop bit was sampled as 0
overrun  output  1  sticky: a byte completed while the FIFO was full

Behaviour:
- Reset (reset=0 at an edge):
  - Synchronizer flops set to 1; tick counter to 0; FSM to IDLE; sample_cnt, bit_idx and shift register to 0.
  - FIFO pointers and count to 0, so rx_valid=0, rx_count=0, rx_data=8'h00.
  - frame_err=0, overrun=0.
  - Reset mid-frame abandons the partial byte and discards all FIFO contents.
- Input synchronizer: two flops; rxd_s is the second flop's output. All decisions use rxd_s, so rxd sees 2 cycles of latency.
- Tick generator:
  - Free-running counter 0..OVS_DIV-1.
  - tick=1 for one clk when the counter equals OVS_DIV-1, then the counter wraps to 0.
- FSM; all transitions happen only on tick cycles:
  - IDLE: if rxd_s=0, go to START with sample_cnt=0.
  - START: increment sample_cnt.
    - When sample_cnt reaches 7 (mid start bit): if rxd_s=0, go to DATA with sample_cnt=0 and bit_idx=0.
    - Otherwise (glitch) return to IDLE with no flag.
  - DATA: increment sample_cnt.
    - At sample_cnt=15: shift = {rxd_s, shift[7:1]} (LSB first), sample_cnt=0, bit_idx+1.
    - After the 8th shift go to STOP.
  - STOP: increment sample_cnt; at sample_cnt=15 (mid stop bit), go to IDLE and:
    - rxd_s=1, FIFO not full: push shift.
    - rxd_s=1, FIFO full with no pop this cycle: drop the byte, set overrun.
    - rxd_s=0: discard the byte, set frame_err; the FIFO is unchanged.
- Re-arm: the return to IDLE happens at mid stop bit, so a start bit directly following the stop bit is detected.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr modulo FIFO_DEPTH; both pointers wrap.
  - rx_data = mem[rd_ptr] when count>0.
  - Pop on rd_en & rx_valid; rd_en while empty is ignored.
  - Pushed data is visible on rx_data and rx_valid on the cycle after the push edge.
- Simultaneous events:
  - Push and pop when full: both occur, count stays FIFO_DEPTH, no overrun.
  - Push and pop when empty: rd_en is ignored, count becomes 1.
  - err_clr in the same cycle as a new error: set wins, flag stays 1.
- Arithmetic: count never exceeds FIFO_DEPTH or goes below 0; sample_cnt is 4 bits; bit_idx is 3 bits plus a done condition.

Test Plan:
Bench uses OVS_DIV=4 (bit = 64 clk).
1. Send 0x55 8N1 with ideal timing -> 0x55 accepted:
   - rx_valid rises 1 clk after the mid-stop tick, about 9.5 bit times after the falling start edge (+2 sync, ±4 clk tick phase).
   - rx_data=0x55, rx_count=1.
   - rd_en pulse -> rx_valid=0, rx_data=0x00.
2. Drive rxd low for 12 clk, then high -> glitch rejected: FSM returns to IDLE, rx_count=0, both error flags 0.
3. Send 0xA5 with stop bit 0 -> frame_err=1, rx_count=0; err_clr pulse -> frame_err=0.
4. Send 0x01,0x02,0x03,0x04,0x05 back-to-back without reads -> overrun=1, rx_count=4; four reads return 0x01..0x04 in order, covering pointer wrap.
5. With FIFO full, assert rd_en on the exact cycle byte 0x66 completes -> overrun stays 0, count stays 4, 0x66 is the last entry.
6. Assert reset=0 for 1 clk mid-DATA of 0x7E with 2 bytes stored -> rx_count=0, FSM IDLE; the next frame 0x3C is received as 0x3C.
